branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-stage dynamic branch predictor that consumes the resolved outcome produced by the execute-stage branch comparator. It looks up a direct-mapped table of 2-bit saturating counters plus branch targets and answers fetch with a taken/not-taken prediction and next PC. Execute writes back the actual outcome (`upd_taken`, driven from the comparator's branch result) to train the table. After every reset, an init sweep clears the table before any lookup or update is served.

## Interface
- `IDX_BITS`, default 6: table index width; table holds 2^IDX_BITS entries.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `pred_valid` input 1: fetch lookup request this cycle.
- `pred_pc` input 32: PC being fetched.
- `pred_resp_valid` output 1: lookup response valid (registered).
- `pred_hit` output 1: lookup matched a valid entry.
- `pred_taken` output 1: predicted taken.
- `pred_target` output 32: predicted next PC.
- `upd_valid` input 1: resolved conditional branch from execute.
- `upd_pc` input 32: PC of the resolved branch.
- `upd_taken` input 1: actual outcome from the branch comparator.
- `upd_target` input 32: computed branch target.
- `init_done` output 1: table sweep complete; block serving requests.

## Operation
- Entry fields: `valid`, `tag` (30-IDX_BITS bits), `ctr` (2 bits), `target` (32 bits).
- Index is `pc[IDX_BITS+1:2]`. Tag is `pc[31:IDX_BITS+2]`. `pc[1:0]` is ignored.
- FSM states:
  - INIT: sweep pointer walks entries 0 to 2^IDX_BITS-1, one per cycle, writing `valid=0`, `ctr=2'b01`. After the last entry is written, go to RUN and set `init_done=1`.
  - RUN: serve lookups and updates. No exit except reset.
- In INIT, lookups and updates are dropped: `pred_resp_valid` stays 0 and the table is not trained.
- Lookup (RUN, `pred_valid=1`): hit means `valid && tag == pred_pc tag`.
  - `pred_taken = hit & ctr[1]`.
  - `pred_target` = entry target when `pred_taken`, else `pred_pc+4` (32-bit wrap; 0xFFFFFFFC+4 gives 0).
- Update (RUN, `upd_valid=1`):
  - Hit, taken: `ctr` increments, saturating at 11; `target` is overwritten with `upd_target`.
  - Hit, not taken: `ctr` decrements, saturating at 00; `target` is unchanged.
  - Miss: allocate the entry. Set `valid=1` and the new tag. Set `ctr=10` if taken, else `01`. Set `target=upd_target`. Any aliasing entry is replaced.
- Simultaneous lookup and update to the same index in the same cycle: the lookup sees pre-update contents (read-before-write).
- At most one lookup and one update per cycle. No backpressure: requests are always accepted in RUN.

## Timing
- Reset values: `pred_resp_valid=0`, `pred_hit=0`, `pred_taken=0`, `pred_target=0`, `init_done=0`. FSM is in INIT with the sweep pointer at 0.
- Asserting reset at any time, including mid-sweep or mid-training, forces these values immediately. The sweep restarts from entry 0 after release.
- INIT lasts exactly 2^IDX_BITS cycles after the first rising edge with `rst_n=1`. `init_done` rises on the edge that writes the last entry.
- The first lookup accepted is one presented with `init_done=1`.
- Lookup latency is 1 cycle: request at edge t gives response outputs valid after edge t+1. `pred_resp_valid` is high for exactly one cycle per accepted request. Other outputs hold their last value when `pred_resp_valid=0`.
- Update latency is 1 cycle: a write at edge t is visible to a lookup presented in the cycle after edge t.

## Test plan
- Init sweep, `IDX_BITS=2`: release reset → `init_done` low for 4 cycles, then high. `pred_valid` pulsed during INIT → no `pred_resp_valid`.
- Cold miss, RUN: lookup `0x100` → `pred_hit=0`, `pred_taken=0`, `pred_target=0x104`. Lookup `0xFFFFFFFC` → `pred_target=0x0`.
- Training: update `0x100` taken, target `0x180` (ctr 10), then taken again (ctr 11) → lookup `0x100` gives `hit=1`, `taken=1`, `target=0x180`.
- Saturation/hysteresis: from ctr 11, one not-taken update → still predicts taken. Second not-taken → predicts not taken, target `0x104`. Two more not-taken → ctr 00. One taken → ctr 01, not taken.
- Aliasing (`IDX_BITS=6`): train `0x100` taken, then update `0x200` (same index, different tag) not-taken → lookup `0x100` misses; lookup `0x200` hits with `taken=0`.
- Same-cycle hazard and mid-op reset: lookup and update on `0x100` in one cycle → response reflects old ctr. Assert `rst_n=0` mid-sweep → all outputs 0 at once; sweep then reruns for the full 2^IDX_BITS cycles, and the table is empty (lookup of the previously trained PC misses).

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/execute side bundle for the branch predictor: lookup request/response,
// resolved-branch training port and the init-complete flag.
interface branch_predictor_if;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_resp_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        init_done;

  modport master (
    output pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_resp_valid, pred_hit, pred_taken, pred_target, init_done
  );

  modport slave (
    input  pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, upd_target,
    output pred_resp_valid, pred_hit, pred_taken, pred_target, init_done
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit saturating-counter branch predictor with target store.
// A post-reset sweep clears every entry before lookups/updates are served.
//
// state  | meaning
// S_INIT | sweep pointer clears one entry per cycle; requests dropped
// S_RUN  | lookups and training updates served every cycle
module branch_predictor #(
  parameter int IDX_BITS = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_predictor_if.slave  bus
);

  localparam int DEPTH = 1 << IDX_BITS;
  localparam int TAG_W = 30 - IDX_BITS;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [IDX_BITS-1:0] ptr_q, ptr_d;

  logic              valid_q  [DEPTH];
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [1:0]        ctr_q    [DEPTH];
  logic [31:0]       target_q [DEPTH];

  logic [IDX_BITS-1:0] rd_idx, up_idx;
  logic [TAG_W-1:0]    rd_tag, up_tag;
  logic                rd_hit, rd_taken, up_hit;
  logic [31:0]         rd_target;
  logic [1:0]          up_ctr;

  logic                we;
  logic [IDX_BITS-1:0] wr_idx;
  logic                wr_valid;
  logic [TAG_W-1:0]    wr_tag;
  logic [1:0]          wr_ctr;
  logic [31:0]         wr_target;

  logic        resp_valid_q, hit_q, taken_q;
  logic [31:0] target_out_q;

  assign rd_idx    = bus.pred_pc[IDX_BITS+1:2];
  assign rd_tag    = bus.pred_pc[31:IDX_BITS+2];
  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_taken  = rd_hit && ctr_q[rd_idx][1];
  assign rd_target = rd_taken ? target_q[rd_idx] : bus.pred_pc + 32'd4;

  assign up_idx = bus.upd_pc[IDX_BITS+1:2];
  assign up_tag = bus.upd_pc[31:IDX_BITS+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_ctr = ctr_q[up_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == IDX_BITS'(DEPTH - 1)) state_d = S_RUN;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // Single table write port: the sweep owns it in INIT, training owns it in RUN.
  always_comb begin
    we        = 1'b0;
    wr_idx    = ptr_q;
    wr_valid  = 1'b0;
    wr_tag    = '0;
    wr_ctr    = 2'b01;
    wr_target = '0;
    if (state_q == S_INIT) begin
      we = 1'b1;
    end else if (bus.upd_valid) begin
      we       = 1'b1;
      wr_idx   = up_idx;
      wr_valid = 1'b1;
      wr_tag   = up_tag;
      if (up_hit) begin
        if (bus.upd_taken) begin
          wr_ctr    = (up_ctr == 2'b11) ? 2'b11 : up_ctr + 2'd1;
          wr_target = bus.upd_target;
        end else begin
          wr_ctr    = (up_ctr == 2'b00) ? 2'b00 : up_ctr - 2'd1;
          wr_target = target_q[up_idx];
        end
      end else begin
        wr_ctr    = bus.upd_taken ? 2'b10 : 2'b01;
        wr_target = bus.upd_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      valid_q[wr_idx]  <= wr_valid;
      tag_q[wr_idx]    <= wr_tag;
      ctr_q[wr_idx]    <= wr_ctr;
      target_q[wr_idx] <= wr_target;
    end
  end

  // Response registers sample the pre-write table, giving read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      taken_q      <= 1'b0;
      target_out_q <= '0;
    end else begin
      resp_valid_q <= (state_q == S_RUN) && bus.pred_valid;
      if ((state_q == S_RUN) && bus.pred_valid) begin
        hit_q        <= rd_hit;
        taken_q      <= rd_taken;
        target_out_q <= rd_target;
      end
    end
  end

  assign bus.pred_resp_valid = resp_valid_q;
  assign bus.pred_hit        = hit_q;
  assign bus.pred_taken      = taken_q;
  assign bus.pred_target     = target_out_q;
  assign bus.init_done       = (state_q == S_RUN);

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic
// checked against an array-based behavioural model of the predictor.
module tb_branch_predictor;
  localparam int IDX   = 6;
  localparam int DEPTH = 1 << IDX;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if bus ();
  branch_predictor_if bus2 ();

  branch_predictor #(.IDX_BITS(IDX)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  branch_predictor #(.IDX_BITS(2))   dut_small (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int errors = 0;
  int checks = 0;

  bit          m_valid [DEPTH];
  logic [31:0] m_tag   [DEPTH];
  int          m_ctr   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  bit          exp_rv, exp_hit, exp_taken;
  logic [31:0] exp_tgt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX + 2);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    exp_rv = 0; exp_hit = 0; exp_taken = 0; exp_tgt = '0;
  endtask

  task automatic cycle(input bit pv, input logic [31:0] ppc, input bit uv,
                       input logic [31:0] upc, input bit ut, input logic [31:0] utgt);
    int i;
    bit h;
    bus.pred_valid = pv;  bus.pred_pc = ppc;
    bus.upd_valid  = uv;  bus.upd_pc  = upc;
    bus.upd_taken  = ut;  bus.upd_target = utgt;
    exp_rv = pv;
    if (pv) begin
      i = idx_of(ppc);
      h = m_valid[i] && (m_tag[i] == tag_of(ppc));
      exp_hit   = h;
      exp_taken = h && (m_ctr[i] >= 2);
      exp_tgt   = exp_taken ? m_tgt[i] : ppc + 32'd4;
    end
    @(posedge clk); #1;
    check("resp_valid", bus.pred_resp_valid, exp_rv);
    check("hit",        bus.pred_hit,        exp_hit);
    check("taken",      bus.pred_taken,      exp_taken);
    check("target",     bus.pred_target,     exp_tgt);
    check("init_done",  bus.init_done,       1);
    if (uv) begin
      i = idx_of(upc);
      if (m_valid[i] && (m_tag[i] == tag_of(upc))) begin
        if (ut) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = utgt;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(upc);
        m_ctr[i]   = ut ? 2 : 1;
        m_tgt[i]   = utgt;
      end
    end
    bus.pred_valid = 1'b0;
    bus.upd_valid  = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    cycle(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic train(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
    cycle(1'b0, 32'h0, 1'b1, pc, t, tgt);
  endtask

  // Asserts reset asynchronously, then runs 'cycles' sweep cycles with lookups pulsed.
  task automatic reset_and_sweep(input int cycles);
    rst_n = 1'b0;
    #1;
    model_clear();
    check("rst_resp_valid", bus.pred_resp_valid, 0);
    check("rst_hit",        bus.pred_hit,        0);
    check("rst_taken",      bus.pred_taken,      0);
    check("rst_target",     bus.pred_target,     0);
    check("rst_init_done",  bus.init_done,       0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.pred_valid  = 1'b1;  bus.pred_pc  = 32'h100;
    bus2.pred_valid = 1'b1;  bus2.pred_pc = 32'h0;
    for (int c = 1; c <= cycles; c++) begin
      @(posedge clk); #1;
      check("sweep_init_done", bus.init_done, 32'(c >= DEPTH));
      check("sweep_resp",      bus.pred_resp_valid, 0);
      if (c <= 4) begin
        check("small_init_done", bus2.init_done, 32'(c >= 4));
        check("small_resp",      bus2.pred_resp_valid, 0);
      end
    end
    bus.pred_valid  = 1'b0;
    bus2.pred_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pc_a, pc_b, tgt;
    bus.pred_valid = 0; bus.pred_pc = 0; bus.upd_valid = 0;
    bus.upd_pc = 0; bus.upd_taken = 0; bus.upd_target = 0;
    bus2.pred_valid = 0; bus2.pred_pc = 0; bus2.upd_valid = 0;
    bus2.upd_pc = 0; bus2.upd_taken = 0; bus2.upd_target = 0;
    #12;
    reset_and_sweep(DEPTH);

    lookup(32'h100);
    check("cold_target", bus.pred_target, 32'h104);
    lookup(32'hFFFF_FFFC);
    check("wrap_target", bus.pred_target, 32'h0);

    train(32'h100, 1'b1, 32'h180);
    train(32'h100, 1'b1, 32'h180);
    lookup(32'h100);
    check("trained_taken", bus.pred_taken, 1);
    check("trained_target", bus.pred_target, 32'h180);

    train(32'h100, 1'b0, 32'h0);
    lookup(32'h100);
    check("hyst_taken", bus.pred_taken, 1);
    train(32'h100, 1'b0, 32'h0);
    lookup(32'h100);
    check("hyst_not_taken", bus.pred_taken, 0);
    check("hyst_target", bus.pred_target, 32'h104);
    train(32'h100, 1'b0, 32'h0);
    train(32'h100, 1'b0, 32'h0);
    train(32'h100, 1'b1, 32'h1A0);
    lookup(32'h100);
    check("sat_low_taken", bus.pred_taken, 0);
    train(32'h100, 1'b1, 32'h1B0);
    lookup(32'h100);
    check("recover_target", bus.pred_target, 32'h1B0);

    train(32'h100, 1'b1, 32'h180);
    train(32'h200, 1'b0, 32'h280);
    lookup(32'h100);
    check("alias_evicted_hit", bus.pred_hit, 0);
    lookup(32'h200);
    check("alias_new_hit", bus.pred_hit, 1);
    check("alias_new_taken", bus.pred_taken, 0);

    train(32'h100, 1'b1, 32'h1C0);
    cycle(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0);
    check("rbw_taken", bus.pred_taken, 1);
    check("rbw_target", bus.pred_target, 32'h1C0);
    lookup(32'h100);
    check("rbw_after_taken", bus.pred_taken, 0);

    for (int n = 0; n < 400; n++) begin
      pc_a = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      pc_b = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) pc_a = 32'hFFFF_FFFC;
      tgt = $urandom;
      cycle(1'($urandom_range(0, 1)), pc_a, 1'($urandom_range(0, 1)), pc_b,
            1'($urandom_range(0, 1)), tgt);
    end

    train(32'h100, 1'b1, 32'h1E0);
    train(32'h100, 1'b1, 32'h1E0);
    lookup(32'h100);
    check("pre_reset_target", bus.pred_target, 32'h1E0);
    reset_and_sweep(20);
    reset_and_sweep(DEPTH);
    lookup(32'h100);
    check("post_reset_hit", bus.pred_hit, 0);
    check("post_reset_target", bus.pred_target, 32'h104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
